// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin LSB-first, one full-adder step per clock,
// then presents the parallel sum and carry-out alongside a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;
  logic             s_d, c_d;

  always_comb begin
    s_d = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_d = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Sum bits enter at the MSB of the A shift register as its consumed bits leave
  // the LSB end, so after WIDTH steps a_sh holds the complete sum.
  if (WIDTH == 1) begin : g_w1
    assign a_sh_d = s_d;
  end else begin : g_wn
    assign a_sh_d = {s_d, a_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= c_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= a_sh_d;
            cout_q  <= c_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1, plus a back-to-back
// random run checked against a + b + cin.
module tb_serial_adder;

  logic       clk, rst_n;
  logic       st8, ci8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       st1, a1, b1, ci1, busy1, done1, sum1, cout1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one operation on the selected instance and wait (bounded) for done.
  // Operands are scrambled right after acceptance; that must not matter.
  task automatic op(input bit w1, input logic [7:0] av, input logic [7:0] bv, input logic civ,
                    output logic [7:0] s, output logic co, output int lat, output int bcnt);
    @(negedge clk);
    if (w1) begin st1 = 1'b1; a1 = av[0]; b1 = bv[0]; ci1 = civ; end
    else    begin st8 = 1'b1; a8 = av;    b8 = bv;    ci8 = civ; end
    @(posedge clk);
    #1;
    st1 = 1'b0; st8 = 1'b0;
    a1 = ~av[0]; b1 = ~bv[0]; ci1 = ~civ;
    a8 = ~av;    b8 = ~bv;    ci8 = ~civ;
    lat = 0; bcnt = 0;
    @(negedge clk);
    while (!(w1 ? done1 : done8) && lat < 40) begin
      if (w1 ? busy1 : busy8) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s  = w1 ? {7'b0, sum1} : sum8;
    co = w1 ? cout1 : cout8;
  endtask

  logic [7:0] s, ra, rb, sum_tab, cout_tab;
  logic       co, rc;
  logic [8:0] rexp;
  int         lat, bcnt, n, evts, last_done;

  initial begin
    rst_n = 1'b0;
    st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    st1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    #3;
    chk("reset8_outputs", {21'b0, busy8, done8, cout8, sum8}, 32'h0);
    chk("reset1_outputs", {28'b0, busy1, done1, cout1, sum1}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 8'h5A, 8'h3C, 1'b0, s, co, lat, bcnt);
    chk("5A+3C_sum", 32'(s), 32'h96);
    chk("5A+3C_cout", 32'(co), 32'h0);
    chk("5A+3C_latency", 32'(lat), 32'd8);
    chk("5A+3C_busy_cycles", 32'(bcnt), 32'd8);
    @(negedge clk);
    chk("done_one_cycle", {30'b0, done8, busy8}, 32'h0);
    chk("sum_hold_after_done", 32'(sum8), 32'h96);

    op(1'b0, 8'hFF, 8'h01, 1'b0, s, co, lat, bcnt);
    chk("FF+01_sum", 32'(s), 32'h00);
    chk("FF+01_cout", 32'(co), 32'h1);
    op(1'b0, 8'hFF, 8'hFF, 1'b1, s, co, lat, bcnt);
    chk("FF+FF+1_sum", 32'(s), 32'hFF);
    chk("FF+FF+1_cout", 32'(co), 32'h1);

    // Full-adder truth table, index {a,b,cin}
    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      op(1'b1, {7'b0, i[2]}, {7'b0, i[1]}, i[0], s, co, lat, bcnt);
      chk($sformatf("w1_sum_%0d", i), 32'(s), 32'(sum_tab[i]));
      chk($sformatf("w1_cout_%0d", i), 32'(co), 32'(cout_tab[i]));
      chk($sformatf("w1_latency_%0d", i), 32'(lat), 32'd1);
    end

    // Starts during RUN and DONE are ignored
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (3) @(negedge clk);
    st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk("ignore_done_seen", 32'(done8), 32'h1);
    chk("ignore_sum", 32'(sum8), 32'h30);
    chk("ignore_cout", 32'(cout8), 32'h0);
    st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    st8 = 1'b0;
    evts = 0;
    repeat (20) begin
      if (done8 || busy8) evts++;
      @(negedge clk);
    end
    chk("ignore_no_extra_op", 32'(evts), 32'h0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {21'b0, busy8, done8, cout8, sum8}, 32'h0);
    st8 = 1'b1;
    repeat (2) @(negedge clk);
    st8 = 1'b0;
    rst_n = 1'b1;
    evts = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) evts++;
    end
    chk("post_reset_quiet", 32'(evts), 32'h0);
    op(1'b0, 8'h0F, 8'h01, 1'b0, s, co, lat, bcnt);
    chk("post_reset_sum", 32'(s), 32'h10);
    chk("post_reset_cout", 32'(co), 32'h0);

    // Back-to-back random operations
    last_done = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      op(1'b0, ra, rb, rc, s, co, lat, bcnt);
      chk($sformatf("rand_%0d_result", i), {23'b0, co, s}, {23'b0, rexp});
      if (i > 0) chk($sformatf("rand_%0d_spacing", i), 32'(cyc - last_done), 32'd10);
      last_done = cyc;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
